// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, buffers returned instructions in a 2-entry FIFO and
// hands them downstream over a valid/ready handshake. Branch redirects flush
// everything in flight and restart fetch from the target.
module fetch_stage #(
    parameter int unsigned      ASIZE    = 16,
    parameter int unsigned      ISIZE    = 32,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ASIZE-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [ISIZE-1:0] imem_data,
    input  logic             redirect,
    input  logic [ASIZE-1:0] redirect_pc,
    output logic             out_valid,
    output logic [ISIZE-1:0] out_inst,
    output logic [ASIZE-1:0] out_pc,
    input  logic             out_ready
);

    logic [ASIZE-1:0] pc_q, pc_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic [ASIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]       count_q, count_d;
    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [ISIZE-1:0] inst_q [2];
    logic [ISIZE-1:0] inst_d [2];
    logic [ASIZE-1:0] epc_q  [2];
    logic [ASIZE-1:0] epc_d  [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ;
    logic       wr_idx;

    // Outputs are forced to their reset values while rst is high, even on the
    // first reset cycle before the state registers have been cleared.
    assign out_valid = ~rst & (count_q != 2'd0);
    assign out_inst  = rst ? '0 : inst_q[0];
    assign out_pc    = rst ? '0 : epc_q[0];

    assign pop  = out_valid & out_ready & ~redirect;
    // A redirect kills the return of the read issued last cycle.
    assign push = inflight_q & ~redirect;
    // Slots that will be committed after this cycle's pop; issue only if one stays free.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = ~rst & (redirect | (occ < 3'd2));

    assign imem_rd = issue;

    // Fetch address selection, PC advance and FIFO next-state.
    always_comb begin
        imem_addr     = addr_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        epc_d         = epc_q;
        count_d       = count_q;
        wr_idx        = 1'b0;

        if (rst) begin
            imem_addr = '0;
        end else if (redirect) begin
            imem_addr = redirect_pc;
            pc_d      = redirect_pc + ASIZE'(1);
        end else if (issue) begin
            imem_addr = pc_q;
            pc_d      = pc_q + ASIZE'(1);
        end

        addr_d        = imem_addr;
        inflight_d    = issue;
        inflight_pc_d = imem_addr;

        if (pop) begin
            inst_d[0] = inst_q[1];
            epc_d[0]  = epc_q[1];
        end
        // The issue rule guarantees count - pop is 0 or 1 whenever a push occurs.
        wr_idx = ((count_q - {1'b0, pop}) == 2'd1);
        if (push) begin
            inst_d[wr_idx] = imem_data;
            epc_d[wr_idx]  = inflight_pc_q;
        end

        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            addr_q        <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            inst_q        <= '{default: '0};
            epc_q         <= '{default: '0};
        end else begin
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            inst_q        <= inst_d;
            epc_q         <= epc_d;
        end
    end

endmodule
